// File: rtl/axi_pkg.sv
// AXI response codes shared by the slave-side blocks.
package axi_pkg;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
endpackage

// File: rtl/axi_ram_rw_arbiter.sv
// AXI4 slave that time-shares one single-port synchronous RAM between whole
// write and read bursts, round-robin on simultaneous requests.
module axi_ram_rw_arbiter
    import axi_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [ID_WIDTH-1:0]                         s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]                       s_axi_awaddr,
    input  logic [7:0]                                  s_axi_awlen,
    input  logic                                        s_axi_awvalid,
    output logic                                        s_axi_awready,
    input  logic [DATA_WIDTH-1:0]                       s_axi_wdata,
    input  logic [STRB_WIDTH-1:0]                       s_axi_wstrb,
    input  logic                                        s_axi_wlast,
    input  logic                                        s_axi_wvalid,
    output logic                                        s_axi_wready,
    output logic [ID_WIDTH-1:0]                         s_axi_bid,
    output logic [1:0]                                  s_axi_bresp,
    output logic                                        s_axi_bvalid,
    input  logic                                        s_axi_bready,
    input  logic [ID_WIDTH-1:0]                         s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]                       s_axi_araddr,
    input  logic [7:0]                                  s_axi_arlen,
    input  logic                                        s_axi_arvalid,
    output logic                                        s_axi_arready,
    output logic [ID_WIDTH-1:0]                         s_axi_rid,
    output logic [DATA_WIDTH-1:0]                       s_axi_rdata,
    output logic [1:0]                                  s_axi_rresp,
    output logic                                        s_axi_rlast,
    output logic                                        s_axi_rvalid,
    input  logic                                        s_axi_rready,
    output logic                                        mem_en,
    output logic [STRB_WIDTH-1:0]                       mem_we,
    output logic [ADDR_WIDTH-$clog2(STRB_WIDTH)-1:0]    mem_addr,
    output logic [DATA_WIDTH-1:0]                       mem_wdata,
    input  logic [DATA_WIDTH-1:0]                       mem_rdata
);
    localparam int ADDR_LSB = $clog2(STRB_WIDTH);
    localparam int MEM_AW   = ADDR_WIDTH - ADDR_LSB;

    typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_t;

    state_t              state;
    logic                last_rd;
    logic [ID_WIDTH-1:0] id_q;
    logic [MEM_AW-1:0]   addr_q;
    logic [7:0]          len_q;
    logic [7:0]          beat_q;
    logic [8:0]          iss_q;
    logic                err_q;
    logic                rvalid_q;

    logic grant_w, w_hs, r_hs, rd_issue, last_beat;
    logic unused_addr_lsb;

    assign unused_addr_lsb = ^{s_axi_awaddr[ADDR_LSB-1:0], s_axi_araddr[ADDR_LSB-1:0]};

    // Write wins a tie only when read had the previous grant.
    assign grant_w       = s_axi_awvalid && (!s_axi_arvalid || last_rd);
    assign s_axi_awready = (state == IDLE) && grant_w;
    assign s_axi_arready = (state == IDLE) && s_axi_arvalid && !grant_w;
    assign s_axi_wready  = (state == WRITE);

    assign w_hs      = s_axi_wready && s_axi_wvalid;
    assign r_hs      = rvalid_q && s_axi_rready;
    assign last_beat = (beat_q == len_q);
    // Only fetch when the R slot is free or being drained this cycle, so
    // mem_rdata (held by the RAM) is the stall buffer.
    assign rd_issue  = (state == READ) && (iss_q <= {1'b0, len_q}) &&
                       (!rvalid_q || s_axi_rready);

    assign mem_en    = w_hs || rd_issue;
    assign mem_we    = w_hs ? s_axi_wstrb : '0;
    assign mem_addr  = addr_q;
    assign mem_wdata = s_axi_wdata;

    assign s_axi_bvalid = (state == WRESP);
    assign s_axi_bid    = id_q;
    assign s_axi_bresp  = (s_axi_bvalid && err_q) ? SLVERR : OKAY;

    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rid    = id_q;
    assign s_axi_rdata  = mem_rdata;
    assign s_axi_rresp  = OKAY;
    assign s_axi_rlast  = rvalid_q && last_beat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last_rd  <= 1'b1;
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            beat_q   <= '0;
            iss_q    <= '0;
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_axi_awready) begin
                        id_q    <= s_axi_awid;
                        addr_q  <= s_axi_awaddr[ADDR_WIDTH-1:ADDR_LSB];
                        len_q   <= s_axi_awlen;
                        beat_q  <= '0;
                        err_q   <= 1'b0;
                        last_rd <= 1'b0;
                        state   <= WRITE;
                    end else if (s_axi_arready) begin
                        id_q    <= s_axi_arid;
                        addr_q  <= s_axi_araddr[ADDR_WIDTH-1:ADDR_LSB];
                        len_q   <= s_axi_arlen;
                        beat_q  <= '0;
                        iss_q   <= '0;
                        last_rd <= 1'b1;
                        state   <= READ;
                    end
                end
                WRITE: begin
                    if (w_hs) begin
                        addr_q <= addr_q + MEM_AW'(1);
                        beat_q <= beat_q + 8'd1;
                        if (s_axi_wlast != last_beat) err_q <= 1'b1;
                        if (last_beat) state <= WRESP;
                    end
                end
                WRESP: begin
                    if (s_axi_bready) begin
                        err_q <= 1'b0;
                        state <= IDLE;
                    end
                end
                READ: begin
                    if (rd_issue) begin
                        addr_q <= addr_q + MEM_AW'(1);
                        iss_q  <= iss_q + 9'd1;
                    end
                    if (rd_issue)          rvalid_q <= 1'b1;
                    else if (s_axi_rready) rvalid_q <= 1'b0;
                    if (r_hs) begin
                        beat_q <= beat_q + 8'd1;
                        if (last_beat) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_ram_rw_arbiter.sv
// Directed bench for axi_ram_rw_arbiter with a behavioural single-port RAM.
module tb_axi_ram_rw_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  awid = '0, arid = '0;
    logic [31:0] awaddr = '0, araddr = '0;
    logic [7:0]  awlen = '0, arlen = '0;
    logic        awvalid = 1'b0, arvalid = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0, wvalid = 1'b0, bready = 1'b0, rready = 1'b0;
    logic        awready, wready, bvalid, arready, rlast, rvalid, mem_en;
    logic [7:0]  bid, rid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, mem_wdata, mem_rdata;
    logic [3:0]  mem_we;
    logic [29:0] mem_addr;

    logic [31:0] ram [0:255];
    int errors = 0;
    int checks = 0;

    axi_ram_rw_arbiter dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = '0;
        mem_rdata = '0;
    end

    // Single-port RAM: byte-write, one-cycle read, output held while disabled.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we == 4'h0) mem_rdata <= ram[mem_addr[7:0]];
            else
                for (int b = 0; b < 4; b++)
                    if (mem_we[b]) ram[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation ran past its time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [31:0] base,
                            input bit bad_wlast, input logic [1:0] exp_resp, input logic [7:0] id);
        int n = 0;
        awaddr = addr; awlen = len; awid = id; awvalid = 1'b1;
        #1;
        while (!awready && n < 20) begin tick(); #1; n++; end
        if (!awready) begin chk("aw_timeout", 0, 1); awvalid = 1'b0; return; end
        tick();
        awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            wdata = base + b; wstrb = 4'hF; wvalid = 1'b1;
            wlast = (b == int'(len)) ^ (bad_wlast && b == 0);
            #1;
            chk("wready", wready, 1);
            chk("w_mem_en", mem_en, 1);
            chk("w_mem_we", mem_we, 4'hF);
            chk("w_mem_addr", mem_addr, (addr >> 2) + b);
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0;
        #1;
        chk("bvalid_latency", bvalid, 1);
        chk("bresp", bresp, exp_resp);
        chk("bid", bid, id);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        #1;
        chk("bvalid_clear", bvalid, 0);
        for (int b = 0; b <= int'(len); b++)
            chk("ram_word", ram[((addr >> 2) + b) & 255], base + b);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [31:0] base,
                           input bit toggle, input logic [7:0] id);
        int n = 0, cyc = 1, beat = 0;
        bit stalled = 0;
        logic [31:0] held = '0;
        araddr = addr; arlen = len; arid = id; arvalid = 1'b1;
        #1;
        while (!arready && n < 20) begin tick(); #1; n++; end
        if (!arready) begin chk("ar_timeout", 0, 1); arvalid = 1'b0; return; end
        tick();
        arvalid = 1'b0;
        while (beat <= int'(len) && cyc < 200) begin
            rready = !toggle || (cyc % 3 == 2);
            #1;
            if (!toggle && cyc == 1) chk("rvalid_cyc1", rvalid, 0);
            if (!toggle && cyc == 2) chk("rvalid_cyc2", rvalid, 1);
            if (rvalid) begin
                if (stalled) chk("rdata_hold", rdata, held);
                if (rready) begin
                    chk("rdata", rdata, base + beat);
                    chk("rlast", rlast, beat == int'(len));
                    chk("rid", rid, id);
                    beat++;
                    stalled = 0;
                end else begin
                    chk("stall_mem_en", mem_en, 0);
                    held = rdata;
                    stalled = 1;
                end
            end else stalled = 0;
            tick();
            cyc++;
        end
        rready = 1'b0;
        if (cyc >= 200) chk("r_timeout", 0, 1);
        #1;
        chk("rvalid_after_last", rvalid, 0);
    endtask

    typedef struct {
        logic aw, ar;
        logic exp_awready, exp_arready;
    } gvec_t;

    gvec_t gtab [4];

    initial begin
        gtab[0] = '{aw: 1'b0, ar: 1'b0, exp_awready: 1'b0, exp_arready: 1'b0};
        gtab[1] = '{aw: 1'b1, ar: 1'b0, exp_awready: 1'b1, exp_arready: 1'b0};
        gtab[2] = '{aw: 1'b0, ar: 1'b1, exp_awready: 1'b0, exp_arready: 1'b1};
        gtab[3] = '{aw: 1'b1, ar: 1'b1, exp_awready: 1'b1, exp_arready: 1'b0};

        do_reset();
        #1;
        chk("rst_awready", awready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_resp", {bresp, rresp}, 0);
        chk("rst_ids", {bid, rid}, 0);
        chk("rst_rlast", rlast, 0);

        // Combinational grant in IDLE; valids drop before the next edge.
        for (int i = 0; i < 4; i++) begin
            tick();
            awvalid = gtab[i].aw; arvalid = gtab[i].ar;
            #1;
            chk("grant_awready", awready, gtab[i].exp_awready);
            chk("grant_arready", arready, gtab[i].exp_arready);
            awvalid = 1'b0; arvalid = 1'b0;
        end

        tick();
        do_write(32'h10, 8'd3, 32'd1, 1'b0, 2'b00, 8'h05);
        do_read(32'h10, 8'd3, 32'd1, 1'b0, 8'h06);

        do_write(32'h20, 8'd7, 32'hA0, 1'b0, 2'b00, 8'h07);
        do_read(32'h20, 8'd7, 32'hA0, 1'b1, 8'h08);

        // Tie straight after reset: write first, then read wins the next tie.
        do_reset();
        araddr = 32'h10; arlen = 8'd3; arid = 8'h11; arvalid = 1'b1;
        awaddr = 32'h100; awlen = 8'd1; awvalid = 1'b1;
        #1;
        chk("tie1_awready", awready, 1);
        chk("tie1_arready", arready, 0);
        do_write(32'h100, 8'd1, 32'h300, 1'b0, 2'b00, 8'h12);
        awvalid = 1'b1;
        #1;
        chk("tie2_arready", arready, 1);
        chk("tie2_awready", awready, 0);
        do_read(32'h10, 8'd3, 32'd1, 1'b0, 8'h11);
        do_write(32'h140, 8'd0, 32'h77, 1'b0, 2'b00, 8'h13);

        do_write(32'h200, 8'd1, 32'h50, 1'b1, 2'b10, 8'h09);

        // Reset while beat 2 of an 8-beat read is on the R channel.
        do_write(32'h300, 8'd7, 32'h70, 1'b0, 2'b00, 8'h0A);
        araddr = 32'h300; arlen = 8'd7; arid = 8'h0B; arvalid = 1'b1;
        #1;
        chk("mid_arready", arready, 1);
        tick();
        arvalid = 1'b0; rready = 1'b1;
        tick(); tick(); tick();
        #1;
        chk("mid_beat2", rdata, 32'h72);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rready = 1'b0;
        #1;
        chk("post_rst_rvalid", rvalid, 0);
        chk("post_rst_arready", arready, 0);
        chk("post_rst_mem_en", mem_en, 0);
        arvalid = 1'b1;
        #1;
        chk("post_rst_idle", arready, 1);
        arvalid = 1'b0;
        tick();
        do_write(32'h3C0, 8'd1, 32'hE0, 1'b0, 2'b00, 8'h0C);
        do_read(32'h3C0, 8'd1, 32'hE0, 1'b0, 8'h0D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
